// File: rtl/lfsr_sched_if.sv
// Requester/config/response bundle between the LFSR scheduler and its clients.
// The scheduler is the slave side; the client cluster (or bench) is the master side.
interface lfsr_sched_if #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int CNTW = 4
);
  localparam int IDW = $clog2(NREQ);

  logic                 cfg_we;
  logic [IDW-1:0]       cfg_id;
  logic [W-1:0]         cfg_seed;
  logic [W-1:0]         cfg_tap;
  logic [NREQ-1:0]      req;
  logic [NREQ*CNTW-1:0] req_steps;
  logic [NREQ-1:0]      gnt;
  logic                 busy;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [W-1:0]         rsp_data;

  modport master (
    output cfg_we, cfg_id, cfg_seed, cfg_tap, req, req_steps,
    input  gnt, busy, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  cfg_we, cfg_id, cfg_seed, cfg_tap, req, req_steps,
    output gnt, busy, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/lfsr_scheduler.sv
// One shared 8-bit Fibonacci LFSR engine time-shared among NREQ requesters, each
// with its own stored state/tap context; round-robin arbitration, one job at a time.
module lfsr_scheduler #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int CNTW = 4
) (
  input  logic        clk,
  input  logic        reset,
  lfsr_sched_if.slave sched
);
  localparam int IDW = $clog2(NREQ);
  localparam logic [W-1:0] SEED_RST = W'(8'h01);
  localparam logic [W-1:0] TAP_RST  = W'(8'hB8);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [CNTW-1:0] n_q, n_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    engine_q, engine_d;
  logic [W-1:0]    tap_q, tap_d;
  logic            dirty_q, dirty_d;

  logic [W-1:0]    ctx_state_q [NREQ];
  logic [W-1:0]    ctx_tap_q   [NREQ];

  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [W-1:0]    rsp_data_q, rsp_data_d;

  logic            found;
  logic [IDW-1:0]  pick;
  logic            cfg_hit;
  logic            wb_en;

  // Round-robin search: first set request strictly after the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && sched.req[idx]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
  end

  assign cfg_hit = sched.cfg_we && (sched.cfg_id == id_q);
  assign wb_en   = (state_q == DONE) && !dirty_q;

  // State register and job datapath.
  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      id_q        <= '0;
      ptr_q       <= IDW'(NREQ - 1);
      n_q         <= '0;
      cnt_q       <= '0;
      engine_q    <= '0;
      tap_q       <= '0;
      dirty_q     <= 1'b0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      ptr_q       <= ptr_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      engine_q    <= engine_d;
      tap_q       <= tap_d;
      dirty_q     <= dirty_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Context store. The cfg write is placed after the writeback so it wins a same-edge collision.
  // NOTE: the context array is explicitly reset because software relies on a
  // known non-zero seed/tap per requester straight out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) begin
        ctx_state_q[i] <= SEED_RST;
        ctx_tap_q[i]   <= TAP_RST;
      end
    end else begin
      if (wb_en) ctx_state_q[id_q] <= engine_q;
      if (sched.cfg_we && (int'(sched.cfg_id) < NREQ)) begin
        ctx_state_q[sched.cfg_id] <= sched.cfg_seed;
        ctx_tap_q[sched.cfg_id]   <= sched.cfg_tap;
      end
    end
  end

  // Next-state logic.
  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    ptr_d    = ptr_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    engine_d = engine_q;
    tap_d    = tap_q;
    dirty_d  = dirty_q | ((state_q != IDLE) && cfg_hit);
    unique case (state_q)
      IDLE: begin
        if (found) begin
          id_d    = pick;
          ptr_d   = pick;
          n_d     = sched.req_steps[int'(pick)*CNTW +: CNTW];
          dirty_d = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        engine_d = ctx_state_q[id_q];
        tap_d    = ctx_tap_q[id_q];
        cnt_d    = n_q;
        state_d  = (n_q == '0) ? DONE : RUN;
      end
      RUN: begin
        engine_d = {engine_q[W-2:0], ^(engine_q & tap_q)};
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CNTW'(1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: registered outputs are derived from the next state so each
  // strobe lines up with the cycle its state occupies.
  always_comb begin
    gnt_d       = '0;
    busy_d      = (state_d != IDLE);
    rsp_valid_d = (state_d == DONE);
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if ((state_q == IDLE) && (state_d == LOAD)) gnt_d[id_d] = 1'b1;
    if (state_d == DONE) begin
      rsp_id_d   = id_q;
      rsp_data_d = engine_d;
    end
  end

  assign sched.gnt       = gnt_q;
  assign sched.busy      = busy_q;
  assign sched.rsp_valid = rsp_valid_q;
  assign sched.rsp_id    = rsp_id_q;
  assign sched.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_lfsr_scheduler.sv
// Directed bench for lfsr_scheduler: reset state, stepping, writeback, round robin,
// zero-step jobs, config collisions and reset abort, all with hand-computed values.
module tb_lfsr_scheduler;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int CNTW = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  lfsr_sched_if #(.NREQ(NREQ), .W(W), .CNTW(CNTW)) bus ();

  lfsr_scheduler #(.NREQ(NREQ), .W(W), .CNTW(CNTW)) dut (
    .clk   (clk),
    .reset (reset),
    .sched (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cfg_we    = 1'b0;
    bus.cfg_id    = '0;
    bus.cfg_seed  = '0;
    bus.cfg_tap   = '0;
    bus.req       = '0;
    bus.req_steps = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic cfg_write(input int id, input logic [7:0] seed, input logic [7:0] tap);
    bus.cfg_we   = 1'b1;
    bus.cfg_id   = 2'(id);
    bus.cfg_seed = seed;
    bus.cfg_tap  = tap;
    tick();
    bus.cfg_we   = 1'b0;
  endtask

  // Drives one request from an IDLE cycle and reports what the DUT did; callers compare.
  task automatic run_job(input int id, input int n, output logic [3:0] g, output int lat,
                         output logic [7:0] data, output logic [1:0] rid, output logic busy_after);
    bus.req_steps[id*CNTW +: CNTW] = 4'(n);
    bus.req[id] = 1'b1;
    tick();
    g = bus.gnt;
    bus.req[id] = 1'b0;
    lat  = -1;
    data = '0;
    rid  = '0;
    for (int c = 2; c <= 40 && lat < 0; c++) begin
      tick();
      if (bus.rsp_valid) begin
        lat  = c;
        data = bus.rsp_data;
        rid  = bus.rsp_id;
      end
    end
    tick();
    busy_after = bus.busy;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.gnt !== 4'b0)     begin n_bad++; $display("FAIL reset_gnt: got %b expected 0000", bus.gnt); end
    n_cmp++; if (bus.busy !== 1'b0)    begin n_bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_id !== 2'd0)  begin n_bad++; $display("FAIL reset_rsp_id: got %0d expected 0", bus.rsp_id); end
    n_cmp++; if (bus.rsp_data !== 8'h00) begin n_bad++; $display("FAIL reset_rsp_data: got %h expected 00", bus.rsp_data); end
  endtask

  task automatic test_basic();
    logic [3:0] g; int lat; logic [7:0] d; logic [1:0] rid; logic ba;
    do_reset();
    cfg_write(0, 8'h01, 8'hB8);
    run_job(0, 4, g, lat, d, rid, ba);
    n_cmp++; if (g !== 4'b0001) begin n_bad++; $display("FAIL basic_gnt: got %b expected 0001", g); end
    n_cmp++; if (lat !== 6)     begin n_bad++; $display("FAIL basic_latency: got %0d expected 6", lat); end
    n_cmp++; if (d !== 8'h11)   begin n_bad++; $display("FAIL basic_data: got %h expected 11", d); end
    n_cmp++; if (rid !== 2'd0)  begin n_bad++; $display("FAIL basic_id: got %0d expected 0", rid); end
    n_cmp++; if (ba !== 1'b0)   begin n_bad++; $display("FAIL basic_busy_after: got %b expected 0", ba); end
    n_cmp++; if (bus.rsp_data !== 8'h11 || bus.rsp_valid !== 1'b0)
      begin n_bad++; $display("FAIL basic_hold: got data %h valid %b expected 11/0", bus.rsp_data, bus.rsp_valid); end
    run_job(0, 1, g, lat, d, rid, ba);
    n_cmp++; if (d !== 8'h23)   begin n_bad++; $display("FAIL writeback_data: got %h expected 23", d); end
    n_cmp++; if (lat !== 3)     begin n_bad++; $display("FAIL writeback_latency: got %0d expected 3", lat); end
  endtask

  task automatic test_round_robin();
    int last_g;
    int waited;
    reset = 1'b1;
    idle_inputs();
    bus.req = 4'b1111;
    tick();
    tick();
    reset = 1'b0;
    last_g = 0;
    for (int k = 0; k < NREQ; k++) begin
      waited = 0;
      while (bus.gnt === 4'b0 && waited < 20) begin tick(); waited++; end
      n_cmp++; if (bus.gnt !== 4'(1 << k))
        begin n_bad++; $display("FAIL rr_gnt_%0d: got %b expected %b", k, bus.gnt, 4'(1 << k)); end
      if (k > 0) begin
        n_cmp++; if (cyc - last_g !== 3)
          begin n_bad++; $display("FAIL rr_spacing_%0d: got %0d expected 3", k, cyc - last_g); end
      end
      last_g = cyc;
      bus.req[k] = 1'b0;
      waited = 0;
      while (bus.rsp_valid !== 1'b1 && waited < 20) begin tick(); waited++; end
      n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h01 || bus.rsp_id !== 2'(k))
        begin n_bad++; $display("FAIL rr_rsp_%0d: got valid %b data %h id %0d expected 1/01/%0d",
                                k, bus.rsp_valid, bus.rsp_data, bus.rsp_id, k); end
      tick();
    end
  endtask

  task automatic test_zero_steps();
    logic [3:0] g; int lat; logic [7:0] d; logic [1:0] rid; logic ba;
    do_reset();
    run_job(3, 0, g, lat, d, rid, ba);
    n_cmp++; if (lat !== 2 || d !== 8'h01 || rid !== 2'd3)
      begin n_bad++; $display("FAIL zero_steps: got lat %0d data %h id %0d expected 2/01/3", lat, d, rid); end
    run_job(3, 1, g, lat, d, rid, ba);
    n_cmp++; if (d !== 8'h02) begin n_bad++; $display("FAIL zero_steps_ctx: got %h expected 02", d); end
  endtask

  task automatic test_cfg_active();
    logic [3:0] g; int lat; logic [7:0] d; logic [1:0] rid; logic ba;
    int waited;
    do_reset();
    bus.req_steps[1*CNTW +: CNTW] = 4'd5;
    bus.req[1] = 1'b1;
    tick();
    bus.req[1] = 1'b0;
    tick();
    tick();
    cfg_write(1, 8'h55, 8'hB8);
    waited = 0;
    while (bus.rsp_valid !== 1'b1 && waited < 20) begin tick(); waited++; end
    n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h23)
      begin n_bad++; $display("FAIL cfg_active_old: got valid %b data %h expected 1/23", bus.rsp_valid, bus.rsp_data); end
    tick();
    run_job(1, 1, g, lat, d, rid, ba);
    n_cmp++; if (d !== 8'hAB) begin n_bad++; $display("FAIL cfg_active_new: got %h expected ab", d); end
  endtask

  task automatic test_cfg_at_done();
    logic [3:0] g; int lat; logic [7:0] d; logic [1:0] rid; logic ba;
    int waited;
    do_reset();
    bus.req_steps[0 +: CNTW] = 4'd1;
    bus.req[0] = 1'b1;
    tick();
    bus.req[0] = 1'b0;
    waited = 0;
    while (bus.rsp_valid !== 1'b1 && waited < 20) begin tick(); waited++; end
    cfg_write(0, 8'h77, 8'hB8);
    run_job(0, 0, g, lat, d, rid, ba);
    n_cmp++; if (d !== 8'h77) begin n_bad++; $display("FAIL cfg_at_done: got %h expected 77", d); end
  endtask

  task automatic test_reset_abort();
    logic [3:0] g; int lat; logic [7:0] d; logic [1:0] rid; logic ba;
    int seen;
    do_reset();
    cfg_write(2, 8'h55, 8'hB8);
    bus.req_steps[2*CNTW +: CNTW] = 4'd15;
    bus.req[2] = 1'b1;
    tick();
    bus.req[2] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL abort_pre_busy: got %b expected 1", bus.busy); end
    reset = 1'b1;
    tick();
    n_cmp++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0)
      begin n_bad++; $display("FAIL abort_busy: got busy %b valid %b expected 0/0", bus.busy, bus.rsp_valid); end
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (bus.rsp_valid === 1'b1) seen++; end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL abort_no_rsp: got %0d strobes expected 0", seen); end
    run_job(2, 1, g, lat, d, rid, ba);
    n_cmp++; if (d !== 8'h02) begin n_bad++; $display("FAIL abort_ctx_reset: got %h expected 02", d); end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_basic();
    test_round_robin();
    test_zero_steps();
    test_cfg_active();
    test_cfg_at_done();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
